// File: rtl/accumulator_ctrl_pkg.sv
// Shared types and helpers for the accumulator sequencer/arbiter.
// State encodings are fixed so board-level debug displays can decode them.
package accumulator_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CHECK = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam int OPCNT_W = 8;

  // Saturating increment for the operation counter.
  function automatic logic [OPCNT_W-1:0] sat_inc(input logic [OPCNT_W-1:0] v);
    return (v == {OPCNT_W{1'b1}}) ? v : v + OPCNT_W'(1);
  endfunction

endpackage

// File: rtl/accumulator_ctrl_if.sv
// Requester-side bus of the accumulator sequencer.
// Handshake: req[i] is a level request with op_data[i*N +: N] held stable while it is high;
// the controller answers with a single-cycle gnt[i] pulse, after which the requester may drop
// or replace req[i]/op_data. A req still high when the controller is idle counts as a new request.
interface accumulator_ctrl_if #(
  parameter int N    = 8,
  parameter int NREQ = 2
) ();

  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] op_data;
  logic              clr_req;
  logic [NREQ-1:0]   gnt;

  modport master (
    output req,
    output op_data,
    output clr_req,
    input  gnt
  );

  modport slave (
    input  req,
    input  op_data,
    input  clr_req,
    output gnt
  );

endinterface

// File: rtl/accumulator_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr, modulo NREQ.
// The pointer register itself lives in the controller.
module accumulator_ctrl_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   winner,
  output logic [NREQ-1:0] onehot
);

  logic [PW:0]   scan;
  logic [PW-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    onehot = '0;
    scan   = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      // Wrap explicitly so non-power-of-two NREQ still scans modulo NREQ.
      scan = {1'b0, ptr} + (PW + 1)'(i);
      if (scan >= (PW + 1)'(NREQ)) begin
        scan = scan - (PW + 1)'(NREQ);
      end
      idx = scan[PW-1:0];
      if (!any && req[idx]) begin
        any         = 1'b1;
        winner      = idx;
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/accumulator_ctrl.sv
// Sequencer/arbiter that shares one free-running accumulator between NREQ requesters:
// one operand per transaction on acc_a, zero otherwise, plus clears and sticky status.
import accumulator_ctrl_pkg::*;

module accumulator_ctrl #(
  parameter int N    = 8,
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  accumulator_ctrl_if.slave   bus,
  input  logic [N-1:0]        acc_s,
  input  logic                acc_cout,
  input  logic                acc_ovf,
  output logic [N-1:0]        acc_a,
  output logic                acc_rst_n,
  output logic                busy,
  output logic                carry_stky,
  output logic                ovf_stky,
  output logic [OPCNT_W-1:0]  op_count,
  output logic [N-1:0]        result,
  output state_t              dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   ptr_nxt;
  logic            arb_any;
  logic [PW-1:0]   arb_winner;
  logic [NREQ-1:0] arb_onehot;
  logic [NREQ-1:0] gnt_q;
  logic            take_op;

  accumulator_ctrl_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .any    (arb_any),
    .winner (arb_winner),
    .onehot (arb_onehot)
  );

  // Clear has priority over any pending request in IDLE.
  assign take_op = (state == ST_IDLE) && !bus.clr_req && arb_any;
  assign ptr_nxt = (arb_winner == PW'(NREQ - 1)) ? '0 : arb_winner + PW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_nxt = ST_CLEAR;
        end else if (arb_any) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_IDLE;
      ST_CLEAR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      acc_a      <= '0;
      gnt_q      <= '0;
      carry_stky <= 1'b0;
      ovf_stky   <= 1'b0;
      op_count   <= '0;
      result     <= '0;
    end else begin
      // acc_a and gnt are only non-zero for the single ISSUE cycle.
      acc_a <= '0;
      gnt_q <= '0;
      if (take_op) begin
        acc_a  <= bus.op_data[arb_winner*N +: N];
        gnt_q  <= arb_onehot;
        rr_ptr <= ptr_nxt;
      end
      case (state)
        ST_CHECK: begin
          result     <= acc_s;
          carry_stky <= carry_stky | acc_cout;
          ovf_stky   <= ovf_stky | acc_ovf;
          op_count   <= sat_inc(op_count);
        end
        ST_CLEAR: begin
          result     <= '0;
          carry_stky <= 1'b0;
          ovf_stky   <= 1'b0;
          op_count   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign acc_rst_n = rst_n & (state != ST_CLEAR);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_accumulator_ctrl.sv
// Bench for accumulator_ctrl with a behavioural accumulator and a spec-level reference model.
// Directed steps followed by randomized transactions; all outputs are sampled on the falling edge.
module tb_accumulator_ctrl;
  import accumulator_ctrl_pkg::*;

  localparam int N    = 8;
  localparam int NREQ = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] acc_s = '0;
  logic         acc_cout = 1'b0;
  logic         acc_ovf = 1'b0;
  logic [N-1:0] acc_a;
  logic         acc_rst_n;
  logic         busy;
  logic         carry_stky;
  logic         ovf_stky;
  logic [7:0]   op_count;
  logic [N-1:0] result;
  state_t       dbg_state;

  accumulator_ctrl_if #(.N(N), .NREQ(NREQ)) bus ();

  accumulator_ctrl #(.N(N), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .acc_s      (acc_s),
    .acc_cout   (acc_cout),
    .acc_ovf    (acc_ovf),
    .acc_a      (acc_a),
    .acc_rst_n  (acc_rst_n),
    .busy       (busy),
    .carry_stky (carry_stky),
    .ovf_stky   (ovf_stky),
    .op_count   (op_count),
    .result     (result),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural accumulator: adds A every clock, registered sum/carry/signed overflow.
  logic [N:0] acc_wide;
  assign acc_wide = {1'b0, acc_s} + {1'b0, acc_a};
  always @(posedge clk) begin
    if (!acc_rst_n) begin
      acc_s    <= '0;
      acc_cout <= 1'b0;
      acc_ovf  <= 1'b0;
    end else begin
      acc_s    <= acc_wide[N-1:0];
      acc_cout <= acc_wide[N];
      acc_ovf  <= (acc_s[N-1] == acc_a[N-1]) && (acc_wide[N-1] != acc_s[N-1]);
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_sum = '0;
  bit         m_c = 1'b0;
  bit         m_v = 1'b0;
  int         m_cnt = 0;
  int         m_ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sum = '0; m_c = 1'b0; m_v = 1'b0; m_cnt = 0; m_ptr = 0;
    exp_q.delete();
  endtask

  task automatic model_clear();
    m_sum = '0; m_c = 1'b0; m_v = 1'b0; m_cnt = 0;
  endtask

  function automatic int model_winner(input logic [NREQ-1:0] pat);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (m_ptr + i) % NREQ;
      if (((pat >> j) & NREQ'(1)) != '0) return j;
    end
    return -1;
  endfunction

  task automatic model_apply(input logic [7:0] d);
    int u;
    int s;
    u = int'(m_sum) + int'(d);
    s = int'($signed(m_sum)) + int'($signed(d));
    if (u > 255) m_c = 1'b1;
    if (s > 127 || s < -128) m_v = 1'b1;
    m_sum = 8'(u);
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    exp_q.push_back(m_sum);
  endtask

  // ---------------- driver tasks (entered on a falling edge in IDLE) ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.op_data = '0; bus.clr_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_acc_a", 32'(acc_a), 32'h0);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_carry", 32'(carry_stky), 32'h0);
    chk("rst_ovf", 32'(ovf_stky), 32'h0);
    chk("rst_opcnt", 32'(op_count), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_acc_rst_n", 32'(acc_rst_n), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rel_busy", 32'(busy), 32'h0);
    chk("rel_acc_a", 32'(acc_a), 32'h0);
    chk("rel_acc_rst_n", 32'(acc_rst_n), 32'h1);
    model_reset();
  endtask

  task automatic do_clear();
    bus.clr_req = 1'b1;
    @(negedge clk);
    chk("clr_state", 32'(dbg_state), 32'(ST_CLEAR));
    chk("clr_acc_rst_n", 32'(acc_rst_n), 32'h0);
    bus.clr_req = 1'b0;
    @(negedge clk);
    model_clear();
    chk("clr_result", 32'(result), 32'h0);
    chk("clr_opcnt", 32'(op_count), 32'h0);
    chk("clr_carry", 32'(carry_stky), 32'h0);
    chk("clr_ovf", 32'(ovf_stky), 32'h0);
  endtask

  // One transaction: present a request pattern, wait for the grant, then check status.
  task automatic arb_txn(input logic [NREQ-1:0] pat, input logic [7:0] d0, input logic [7:0] d1,
                         input bit hold, output logic [NREQ-1:0] g_obs);
    int         t;
    int         w;
    logic [7:0] d;
    bus.req = pat;
    bus.op_data = {d1, d0};
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.gnt == '0 && t < 8);
    g_obs = bus.gnt;
    chk("gnt_seen", 32'(bus.gnt != '0), 32'h1);
    if (bus.gnt == '0) begin
      bus.req = '0;
      return;
    end
    w = model_winner(pat);
    d = (w == 1) ? d1 : d0;
    chk("gnt_onehot", 32'(bus.gnt), 32'(NREQ'(1) << w));
    chk("issue_acc_a", 32'(acc_a), 32'(d));
    chk("issue_busy", 32'(busy), 32'h1);
    model_apply(d);
    m_ptr = (w + 1) % NREQ;
    if (!hold) bus.req = '0;
    @(negedge clk);
    chk("check_gnt", 32'(bus.gnt), 32'h0);
    chk("check_acc_a", 32'(acc_a), 32'h0);
    @(negedge clk);
    chk("result", 32'(result), 32'(exp_q.pop_front()));
    chk("op_count", 32'(op_count), 32'(m_cnt));
    chk("carry_stky", 32'(carry_stky), 32'(m_c));
    chk("ovf_stky", 32'(ovf_stky), 32'(m_v));
    chk("idle_busy", 32'(busy), 32'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] rr_exp [4];
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    bus.req = '0; bus.op_data = '0; bus.clr_req = 1'b0;

    // reset
    do_reset();

    // single operations on requester 0
    arb_txn(2'b01, 8'h05, 8'h00, 1'b0, g);
    chk("single_gnt", 32'(g), 32'h1);
    chk("single_res1", 32'(result), 32'h05);
    chk("single_cnt1", 32'(op_count), 32'h1);
    arb_txn(2'b01, 8'h03, 8'h00, 1'b0, g);
    chk("single_res2", 32'(result), 32'h08);

    // round-robin with both requests held, starting from a fresh pointer
    do_reset();
    for (int k = 0; k < 4; k++) begin
      arb_txn(2'b11, 8'h01, 8'h10, 1'b1, g);
      chk("rr_order", 32'(g), 32'(rr_exp[k]));
    end
    bus.req = '0;
    chk("rr_result", 32'(result), 32'h22);
    chk("rr_opcnt", 32'(op_count), 32'h4);

    // sticky flags
    do_clear();
    arb_txn(2'b01, 8'h7F, 8'h00, 1'b0, g);
    arb_txn(2'b01, 8'h01, 8'h00, 1'b0, g);
    chk("flag_res80", 32'(result), 32'h80);
    chk("flag_ovf1", 32'(ovf_stky), 32'h1);
    chk("flag_carry0", 32'(carry_stky), 32'h0);
    arb_txn(2'b10, 8'h00, 8'h80, 1'b0, g);
    chk("flag_res00", 32'(result), 32'h00);
    chk("flag_carry1", 32'(carry_stky), 32'h1);
    arb_txn(2'b01, 8'h05, 8'h00, 1'b0, g);
    chk("flag_carry_hold", 32'(carry_stky), 32'h1);
    chk("flag_ovf_hold", 32'(ovf_stky), 32'h1);

    // clear wins over a same-cycle request; request served right after
    bus.clr_req = 1'b1;
    bus.req = 2'b01;
    bus.op_data = {8'h00, 8'h11};
    @(negedge clk);
    chk("prio_state", 32'(dbg_state), 32'(ST_CLEAR));
    chk("prio_acc_rst_n", 32'(acc_rst_n), 32'h0);
    chk("prio_no_gnt", 32'(bus.gnt), 32'h0);
    bus.clr_req = 1'b0;
    @(negedge clk);
    model_clear();
    chk("prio_opcnt", 32'(op_count), 32'h0);
    chk("prio_result", 32'(result), 32'h0);
    chk("prio_carry", 32'(carry_stky), 32'h0);
    chk("prio_ovf", 32'(ovf_stky), 32'h0);
    chk("prio_acc_rst_n_rel", 32'(acc_rst_n), 32'h1);
    arb_txn(2'b01, 8'h11, 8'h00, 1'b0, g);
    chk("prio_gnt", 32'(g), 32'h1);
    chk("prio_res", 32'(result), 32'h11);

    // randomized traffic with occasional clears
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) do_clear();
      arb_txn(NREQ'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 1'b0, g);
    end

    // op_count saturation
    do_clear();
    for (int k = 0; k < 256; k++) begin
      arb_txn(2'b01, 8'h00, 8'h00, 1'b0, g);
    end
    chk("sat_opcnt", 32'(op_count), 32'd255);

    // reset while an operand is in ISSUE
    bus.req = 2'b01;
    bus.op_data = {8'h00, 8'h42};
    @(negedge clk);
    chk("midrst_issue", 32'(dbg_state), 32'(ST_ISSUE));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("midrst_result", 32'(result), 32'h0);
    chk("midrst_acc_rst_n", 32'(acc_rst_n), 32'h0);
    chk("midrst_opcnt", 32'(op_count), 32'h0);
    chk("midrst_gnt", 32'(bus.gnt), 32'h0);
    bus.req = '0;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_release", 32'(acc_rst_n), 32'h1);
    chk("midrst_acc_s", 32'(acc_s), 32'h0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
